// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and default constants for the PLL lock supervisor.
package pll_sup_pkg;

    // State encoding is visible on state_o, so the values are fixed.
    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    localparam int DEF_AREST_CYC        = 16;
    localparam int DEF_LOCK_TIMEOUT_CYC = 65536;
    localparam int DEF_LOCK_STABLE_CYC  = 1024;
    localparam int DEF_MAX_RETRY        = 7;
    localparam int DEF_CNT_W            = 17;

    // The PLL is held in reset while sequencing its reset pulse and after giving up.
    function automatic logic areset_of(state_t s);
        return (s == S_RESET) || (s == S_FAIL);
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// PLL-side and status signals of the lock supervisor.
interface pll_lock_supervisor_if;
    logic       pll_locked;
    logic       soft_restart;
    logic       pll_areset;
    logic       sys_rst_n;
    logic       fail;
    logic [2:0] state_o;
    logic [7:0] relock_cnt;

    // The supervisor itself.
    modport slave (
        input  pll_locked,
        input  soft_restart,
        output pll_areset,
        output sys_rst_n,
        output fail,
        output state_o,
        output relock_cnt
    );

    // Whatever drives lock/restart and observes the resets.
    modport master (
        output pll_locked,
        output soft_restart,
        input  pll_areset,
        input  sys_rst_n,
        input  fail,
        input  state_o,
        input  relock_cnt
    );
endinterface

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop synchroniser for asynchronous status inputs.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    // Shift the input one stage per clock.
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    // Synchroniser flops, cleared only by the hard reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives the PLL reset pin and holds the system in reset until lock is stable.
// Runs from the board oscillator so it keeps working while the PLL is unlocked.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int AREST_CYC        = DEF_AREST_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int MAX_RETRY        = DEF_MAX_RETRY,
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic                   ext_clk,
    input  logic                   ext_rst,
    pll_lock_supervisor_if.slave   bus
);

    // Terminal counts; each state compares against its own limit so cnt never wraps.
    localparam logic [CNT_W-1:0] AREST_LAST   = CNT_W'(AREST_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRY);

    logic             locked_s;
    state_t           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [7:0]       retry_d, retry_q;
    logic [7:0]       retry_inc;
    logic [7:0]       relock_d, relock_q;
    logic             pll_areset_d, pll_areset_q;
    logic             sys_rst_n_d, sys_rst_n_q;
    logic             fail_d, fail_q;

    // pll_locked comes from the PLL's own domain; only the synchronised copy is used.
    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk      (ext_clk),
        .srst     (ext_rst),
        .async_in (bus.pll_locked),
        .sync_out (locked_s)
    );

    // Next-state, shared counter, retry and relock bookkeeping.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        relock_d  = relock_q;
        retry_inc = retry_q + 8'd1;

        if (bus.soft_restart) begin
            // Restart wins over any transition, so a lock loss in the same
            // cycle is not counted as a relock.
            state_d = S_RESET;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                S_RESET: begin
                    if (cnt_q == AREST_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_d = retry_inc;
                        cnt_d   = '0;
                        state_d = (retry_inc == RETRY_LIMIT) ? S_FAIL : S_RESET;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_STABLE: begin
                    // A dropout here is a glitch filter, not a failed attempt:
                    // go back to waiting with a fresh timeout window.
                    if (!locked_s) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_d = S_RESET;
                        cnt_d   = '0;
                        if (relock_q != 8'hFF) begin
                            relock_d = relock_q + 8'd1;
                        end
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_RESET;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and bookkeeping registers.
    always_ff @(posedge ext_clk) begin
        if (ext_rst) begin
            state_q  <= S_RESET;
            cnt_q    <= '0;
            retry_q  <= '0;
            relock_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            relock_q <= relock_d;
        end
    end

    // Outputs decode the next state so they switch on the same edge as state_o.
    always_comb begin
        pll_areset_d = areset_of(state_d);
        sys_rst_n_d  = (state_d == S_RUN);
        fail_d       = (state_d == S_FAIL);
    end

    // Registered outputs; the PLL is held in reset and the system in reset at power-up.
    always_ff @(posedge ext_clk) begin
        if (ext_rst) begin
            pll_areset_q <= 1'b1;
            sys_rst_n_q  <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            pll_areset_q <= pll_areset_d;
            sys_rst_n_q  <= sys_rst_n_d;
            fail_q       <= fail_d;
        end
    end

    assign bus.pll_areset = pll_areset_q;
    assign bus.sys_rst_n  = sys_rst_n_q;
    assign bus.fail       = fail_q;
    assign bus.state_o    = state_q;
    assign bus.relock_cnt = relock_q;

endmodule
